register_file_mp: RTL



---
 rtl/cpu_types_pkg.sv | 16 +
 rtl/register_file_wb_ctrl.sv | 97 +++++++++
 rtl/register_file_mp.sv | 72 +++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared write-back select types for the register file and its controller.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    DST_RT   = 2'd0,
    DST_RD   = 2'd1,
    DST_LINK = 2'd2
  } wdst_t;

  typedef enum logic [1:0] {
    SRC_ALU = 2'd0,
    SRC_MEM = 2'd1,
    SRC_PC4 = 2'd2
  } wsrc_t;

endpackage

// File: rtl/register_file_wb_ctrl.sv
// Write-back controller: destination decode, data select, and the load-wait FSM.
//   state     | meaning
//   IDLE      | accepting write-back requests
//   LOAD_WAIT | load issued without data; waiting for dhit, new requests ignored
module register_file_wb_ctrl
  import cpu_types_pkg::*;
#(
  parameter int AW       = 5,
  parameter int DATA_W   = 32,
  parameter int LINK_REG = 31
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [31:0]       wr_instr,
  input  logic [1:0]        wdst,
  input  logic [1:0]        wsrc,
  input  logic              reg_write,
  input  logic              ihit,
  input  logic              dhit,
  input  logic [DATA_W-1:0] alu_res,
  input  logic [DATA_W-1:0] pc4,
  input  logic [DATA_W-1:0] dload,
  output logic              busy,
  output logic              wr_commit,
  output logic [AW-1:0]     waddr,
  output logic [DATA_W-1:0] wdata
);

  typedef enum logic {IDLE, LOAD_WAIT} state_t;

  localparam logic [AW-1:0] LINK_A = AW'(LINK_REG);

  state_t          state, state_nxt;
  logic [AW-1:0]   cap_addr;
  logic [AW-1:0]   dest_addr;
  logic [DATA_W-1:0] src_data;
  logic            req;
  logic            unused_instr;

  // Only the rt/rd fields matter; the rest of the instruction is don't-care here.
  assign unused_instr = ^wr_instr;
  assign req          = reg_write & ihit;

  always_comb begin
    dest_addr = AW'(wr_instr[20:16]);
    case (wdst_t'(wdst))
      DST_RD:   dest_addr = AW'(wr_instr[15:11]);
      DST_LINK: dest_addr = LINK_A;
      default:  dest_addr = AW'(wr_instr[20:16]);
    endcase
  end

  always_comb begin
    src_data = alu_res;
    case (wsrc_t'(wsrc))
      SRC_MEM: src_data = dload;
      SRC_PC4: src_data = pc4;
      default: src_data = alu_res;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      cap_addr <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && state_nxt == LOAD_WAIT) cap_addr <= dest_addr;
    end
  end

  always_comb begin
    state_nxt = state;
    wr_commit = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (wsrc_t'(wsrc) != SRC_MEM || dhit) wr_commit = 1'b1;
          else                                   state_nxt = LOAD_WAIT;
        end
      end
      LOAD_WAIT: begin
        if (dhit) begin
          wr_commit = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (RST) wr_commit = 1'b0;
  end

  assign busy  = (state == LOAD_WAIT);
  assign waddr = (state == LOAD_WAIT) ? cap_addr : dest_addr;
  assign wdata = (state == LOAD_WAIT) ? dload : src_data;

endmodule

// File: rtl/register_file_mp.sv
// Multi-read-port register file; register 0 is hardwired to zero, optional write bypass.
module register_file_mp
  import cpu_types_pkg::*;
#(
  parameter int NREGS    = 32,
  parameter int DATA_W   = 32,
  parameter int NRD      = 2,
  parameter int BYPASS   = 1,
  parameter int LINK_REG = NREGS - 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [NRD*AW-1:0]     raddr,
  output logic [NRD*DATA_W-1:0] rdat,
  input  logic [31:0]           wr_instr,
  input  logic [1:0]            wdst,
  input  logic [1:0]            wsrc,
  input  logic                  reg_write,
  input  logic                  ihit,
  input  logic                  dhit,
  input  logic [DATA_W-1:0]     alu_res,
  input  logic [DATA_W-1:0]     pc4,
  input  logic [DATA_W-1:0]     dload,
  output logic                  busy,
  output logic                  wr_commit
);

  logic [DATA_W-1:0] regs [NREGS];
  logic [AW-1:0]     waddr;
  logic [DATA_W-1:0] wdata;

  register_file_wb_ctrl #(
    .AW       (AW),
    .DATA_W   (DATA_W),
    .LINK_REG (LINK_REG)
  ) u_wb_ctrl (
    .CLK       (CLK),
    .RST       (RST),
    .wr_instr  (wr_instr),
    .wdst      (wdst),
    .wsrc      (wsrc),
    .reg_write (reg_write),
    .ihit      (ihit),
    .dhit      (dhit),
    .alu_res   (alu_res),
    .pc4       (pc4),
    .dload     (dload),
    .busy      (busy),
    .wr_commit (wr_commit),
    .waddr     (waddr),
    .wdata     (wdata)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_commit && waddr != '0) begin
      regs[waddr] <= wdata;
    end
  end

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [AW-1:0] ra;
    logic          fwd;
    assign ra  = raddr[g*AW +: AW];
    // Forwarding never applies to register 0, even though its write still commits.
    assign fwd = (BYPASS != 0) && wr_commit && (ra == waddr) && (waddr != '0);
    assign rdat[g*DATA_W +: DATA_W] = fwd ? wdata : ((ra == '0) ? '0 : regs[ra]);
  end

endmodule
